// File: rtl/rv_wb_trace_fifo_if.sv
// ---------------------------------------------------------------------------
// rv_wb_trace_fifo_if
// Bundles the two bus-like sides of the write-back trace FIFO:
//   capture side : reg_write, wb_rd, write_data, pc_in   (core -> FIFO)
//   drain side   : out_valid, out_pc, out_rd, out_data, out_seq (FIFO -> sink)
//                  out_ready                                (sink -> FIFO)
// Modports:
//   slave  : the trace FIFO itself
//   master : the core/sink pair (or a testbench standing in for them)
// ---------------------------------------------------------------------------
interface rv_wb_trace_fifo_if #(
   parameter int XLEN  = 64,
   parameter int PC_W  = 64,
   parameter int SEQ_W = 32
);
   logic             reg_write;
   logic [4:0]       wb_rd;
   logic [XLEN-1:0]  write_data;
   logic [PC_W-1:0]  pc_in;

   logic             out_valid;
   logic             out_ready;
   logic [PC_W-1:0]  out_pc;
   logic [4:0]       out_rd;
   logic [XLEN-1:0]  out_data;
   logic [SEQ_W-1:0] out_seq;

   modport slave (
      input  reg_write, wb_rd, write_data, pc_in, out_ready,
      output out_valid, out_pc, out_rd, out_data, out_seq
   );

   modport master (
      output reg_write, wb_rd, write_data, pc_in, out_ready,
      input  out_valid, out_pc, out_rd, out_data, out_seq
   );
endinterface

// File: rtl/rv_wb_trace_fifo.sv
// ---------------------------------------------------------------------------
// rv_wb_trace_fifo
// Captures RISC-V write-back (retire) events, tags each with a sequence
// number and buffers them in a first-word-fall-through FIFO that a trace
// sink drains through a valid/ready port.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   en        : capture enable (0 = freeze captures, draining continues)
//   clear     : synchronous flush of FIFO contents and drop counter
//   bus       : rv_wb_trace_fifo_if.slave (capture inputs + drain port)
//   count     : FIFO occupancy
//   full      : count == DEPTH
//   empty     : count == 0
//   drop_cnt  : saturating count of events lost to overflow
// ---------------------------------------------------------------------------
module rv_wb_trace_fifo #(
   parameter int XLEN      = 64,
   parameter int PC_W      = 64,
   parameter int DEPTH     = 16,
   parameter int SEQ_W     = 32,
   parameter int DROP_W    = 16,
   parameter bit FILTER_X0 = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       clear,
   rv_wb_trace_fifo_if.slave          bus,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic [DROP_W-1:0]          drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Pointers carry one extra wrap bit so full and empty can be told apart
   // when the index bits match.
   logic [CW-1:0]     wr_ptr;
   logic [CW-1:0]     rd_ptr;
   logic [CW-1:0]     count_q;
   logic [SEQ_W-1:0]  seq_q;
   logic [DROP_W-1:0] drop_q;
   logic              has_data;

   logic [XLEN-1:0]   mem_data [DEPTH];
   logic [PC_W-1:0]   mem_pc   [DEPTH];
   logic [4:0]        mem_rd   [DEPTH];
   logic [SEQ_W-1:0]  mem_seq  [DEPTH];

   logic evt;
   logic pop;
   logic push;
   logic drop;
   logic is_x0;

   // Status flags come straight from the pointer compare.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign count = count_q;
   assign drop_cnt = drop_q;

   // Event qualification and the handshake decisions. A full FIFO can still
   // accept a new entry when the head leaves in the same cycle.
   assign is_x0 = FILTER_X0 && (bus.wb_rd == 5'd0);
   assign evt   = en && bus.reg_write && !is_x0;
   assign pop   = !empty && bus.out_ready;
   assign push  = evt && (!full || pop);
   assign drop  = evt && full && !pop;

   // Head of the FIFO falls through to the outputs. Until the first entry
   // after reset is written, the storage holds garbage, so the outputs are
   // forced to zero instead.
   assign bus.out_valid = !empty;
   assign bus.out_pc    = has_data ? mem_pc[rd_ptr[AW-1:0]]   : '0;
   assign bus.out_rd    = has_data ? mem_rd[rd_ptr[AW-1:0]]   : '0;
   assign bus.out_data  = has_data ? mem_data[rd_ptr[AW-1:0]] : '0;
   assign bus.out_seq   = has_data ? mem_seq[rd_ptr[AW-1:0]]  : '0;

   // Storage array has no reset; only the slot at the write pointer changes.
   // A clear in the same cycle discards the incoming event.
   always_ff @(posedge clk) begin
      if (push && !clear && !rst) begin
         mem_data[wr_ptr[AW-1:0]] <= bus.write_data;
         mem_pc[wr_ptr[AW-1:0]]   <= bus.pc_in;
         mem_rd[wr_ptr[AW-1:0]]   <= bus.wb_rd;
         mem_seq[wr_ptr[AW-1:0]]  <= seq_q;
      end
   end

   // Control state: pointers, occupancy, sequence and drop counters.
   // The sequence counter advances on every qualified event, including those
   // dropped or flushed by clear, so losses show up as gaps in out_seq.
   // clear wins over push/pop but leaves the sequence counter alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         seq_q    <= '0;
         drop_q   <= '0;
         has_data <= 1'b0;
      end else begin
         if (evt) begin
            seq_q <= seq_q + SEQ_W'(1);
         end
         if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
         end else begin
            if (push) begin
               wr_ptr   <= wr_ptr + CW'(1);
               has_data <= 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + CW'(1);
            end
            if (push && !pop) begin
               count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
               count_q <= count_q - CW'(1);
            end
            if (drop && (drop_q != {DROP_W{1'b1}})) begin
               drop_q <= drop_q + DROP_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_rv_wb_trace_fifo.sv
// ---------------------------------------------------------------------------
// tb_rv_wb_trace_fifo
// Directed self-checking bench for rv_wb_trace_fifo. Instance dutA uses the
// default configuration (DEPTH 16, x0 filtered, 16-bit drop counter);
// instance dutB is a tiny 2-entry FIFO with x0 capture enabled and a 2-bit
// drop counter so that saturation is reached in a handful of cycles.
// ---------------------------------------------------------------------------
module tb_rv_wb_trace_fifo;

   logic clk;
   logic rst;
   logic en;
   logic clear;

   logic [4:0]  countA;
   logic        fullA;
   logic        emptyA;
   logic [15:0] dropA;

   logic [1:0]  countB;
   logic        fullB;
   logic        emptyB;
   logic [1:0]  dropB;

   int assertCount = 0;
   int failCount   = 0;

   rv_wb_trace_fifo_if #(.XLEN(64), .PC_W(64), .SEQ_W(32)) busA ();
   rv_wb_trace_fifo_if #(.XLEN(64), .PC_W(64), .SEQ_W(32)) busB ();

   rv_wb_trace_fifo #(
      .XLEN(64), .PC_W(64), .DEPTH(16), .SEQ_W(32), .DROP_W(16), .FILTER_X0(1'b1)
   ) dutA (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .bus(busA),
      .count(countA), .full(fullA), .empty(emptyA), .drop_cnt(dropA)
   );

   rv_wb_trace_fifo #(
      .XLEN(64), .PC_W(64), .DEPTH(2), .SEQ_W(32), .DROP_W(2), .FILTER_X0(1'b0)
   ) dutB (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .bus(busB),
      .count(countB), .full(fullB), .empty(emptyB), .drop_cnt(dropB)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle of capture/drain inputs onto the selected instance
   // (sel 0 = dutA, 1 = dutB), holds the other idle, then advances to just
   // after the next rising edge so outputs can be sampled safely.
   task automatic applyStimulus(input bit sel, input logic rw, input logic [4:0] rd,
                                input logic [63:0] data, input logic [63:0] pc,
                                input logic rdy);
      busA.reg_write  = (sel == 1'b0) ? rw  : 1'b0;
      busA.wb_rd      = rd;
      busA.write_data = data;
      busA.pc_in      = pc;
      busA.out_ready  = (sel == 1'b0) ? rdy : 1'b0;
      busB.reg_write  = (sel == 1'b1) ? rw  : 1'b0;
      busB.wb_rd      = rd;
      busB.write_data = data;
      busB.pc_in      = pc;
      busB.out_ready  = (sel == 1'b1) ? rdy : 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts it and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Linear directed sequence; every expected value is worked out by hand.
   initial begin
      rst   = 1'b1;
      en    = 1'b1;
      clear = 1'b0;
      busA.reg_write = 1'b0; busA.wb_rd = '0; busA.write_data = '0; busA.pc_in = '0; busA.out_ready = 1'b0;
      busB.reg_write = 1'b0; busB.wb_rd = '0; busB.write_data = '0; busB.pc_in = '0; busB.out_ready = 1'b0;

      // Reset state
      applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0);
      checkOutput("rst_valid", busA.out_valid, 64'd0);
      checkOutput("rst_empty", emptyA, 64'd1);
      checkOutput("rst_full", fullA, 64'd0);
      checkOutput("rst_count", countA, 64'd0);
      checkOutput("rst_drop", dropA, 64'd0);
      checkOutput("rst_seq", busA.out_seq, 64'd0);
      checkOutput("rst_data", busA.out_data, 64'd0);
      checkOutput("rst_emptyB", emptyB, 64'd1);
      rst = 1'b0;

      // Three events with the sink always ready: one-cycle visibility
      applyStimulus(1'b0, 1'b1, 5'd1, 64'h11, 64'h0, 1'b1);
      checkOutput("ev0_valid", busA.out_valid, 64'd1);
      checkOutput("ev0_seq", busA.out_seq, 64'd0);
      checkOutput("ev0_rd", busA.out_rd, 64'd1);
      checkOutput("ev0_data", busA.out_data, 64'h11);
      applyStimulus(1'b0, 1'b1, 5'd2, 64'h22, 64'h4, 1'b1);
      checkOutput("ev1_seq", busA.out_seq, 64'd1);
      checkOutput("ev1_pc", busA.out_pc, 64'h4);
      checkOutput("ev1_count", countA, 64'd1);
      applyStimulus(1'b0, 1'b1, 5'd3, 64'h33, 64'h8, 1'b1);
      checkOutput("ev2_seq", busA.out_seq, 64'd2);
      checkOutput("ev2_data", busA.out_data, 64'h33);
      checkOutput("ev2_drop", dropA, 64'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b1);
      checkOutput("drain3_empty", emptyA, 64'd1);

      // Write to x0 is filtered and consumes no sequence number
      applyStimulus(1'b0, 1'b1, 5'd0, 64'h99, 64'hC, 1'b0);
      checkOutput("x0_empty", emptyA, 64'd1);
      applyStimulus(1'b0, 1'b1, 5'd5, 64'h55, 64'h10, 1'b0);
      checkOutput("x0_next_seq", busA.out_seq, 64'd3);
      checkOutput("x0_next_rd", busA.out_rd, 64'd5);
      applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b1);

      // Overflow: fresh reset, 20 events into 16 entries with sink stalled
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b1, 5'((i % 31) + 1), 64'(i + 256), 64'(i * 4), 1'b0);
      end
      checkOutput("ovf_full", fullA, 64'd1);
      checkOutput("ovf_count", countA, 64'd16);
      checkOutput("ovf_drop", dropA, 64'd4);
      checkOutput("ovf_head_seq", busA.out_seq, 64'd0);
      checkOutput("ovf_head_data", busA.out_data, 64'h100);

      // Full plus simultaneous pop: push accepted, count and drops unchanged
      applyStimulus(1'b0, 1'b1, 5'd7, 64'hAA, 64'h200, 1'b1);
      checkOutput("fp_count", countA, 64'd16);
      checkOutput("fp_drop", dropA, 64'd4);
      checkOutput("fp_full", fullA, 64'd1);

      // Drain: seq 1..15 from the fill, then the entry captured as seq 20
      for (int j = 0; j < 16; j++) begin
         checkOutput($sformatf("drain_seq%0d", j), busA.out_seq, (j < 15) ? 64'(j + 1) : 64'd20);
         if (j == 15) begin
            checkOutput("drain_tail_rd", busA.out_rd, 64'd7);
            checkOutput("drain_tail_data", busA.out_data, 64'hAA);
         end
         applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b1);
      end
      checkOutput("drain_empty", emptyA, 64'd1);
      checkOutput("drain_count", countA, 64'd0);

      // Small instance: x0 captured, then drop counter saturates at 3
      applyStimulus(1'b1, 1'b1, 5'd0, 64'h5, 64'h40, 1'b0);
      checkOutput("b_x0_valid", busB.out_valid, 64'd1);
      checkOutput("b_x0_rd", busB.out_rd, 64'd0);
      checkOutput("b_x0_seq", busB.out_seq, 64'd0);
      applyStimulus(1'b1, 1'b1, 5'd1, 64'h6, 64'h44, 1'b0);
      checkOutput("b_full", fullB, 64'd1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b1, 5'd2, 64'h7, 64'h48, 1'b0);
      end
      checkOutput("b_drop3", dropB, 64'd3);
      applyStimulus(1'b1, 1'b1, 5'd2, 64'h7, 64'h48, 1'b0);
      applyStimulus(1'b1, 1'b1, 5'd2, 64'h7, 64'h48, 1'b0);
      checkOutput("b_drop_sat", dropB, 64'd3);
      checkOutput("b_count", countB, 64'd2);

      // Clear with a coincident event: flushed, drops zeroed, seq consumed
      clear = 1'b1;
      applyStimulus(1'b1, 1'b1, 5'd8, 64'h8, 64'h4C, 1'b0);
      clear = 1'b0;
      checkOutput("clr_emptyB", emptyB, 64'd1);
      checkOutput("clr_dropB", dropB, 64'd0);
      checkOutput("clr_dropA", dropA, 64'd0);
      applyStimulus(1'b1, 1'b1, 5'd9, 64'h9, 64'h50, 1'b0);
      checkOutput("clr_next_seq", busB.out_seq, 64'd8);
      checkOutput("clr_next_rd", busB.out_rd, 64'd9);

      // Reset mid-stream with five entries queued (dutA seq resumes at 21)
      for (int m = 0; m < 5; m++) begin
         applyStimulus(1'b0, 1'b1, 5'd4, 64'(m + 64'h300), 64'(m * 4), 1'b0);
      end
      checkOutput("mid_count", countA, 64'd5);
      checkOutput("mid_head_seq", busA.out_seq, 64'd21);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b1, 5'd4, 64'h3FF, 64'h0, 1'b1);
      rst = 1'b0;
      checkOutput("mid_rst_empty", emptyA, 64'd1);
      checkOutput("mid_rst_valid", busA.out_valid, 64'd0);
      checkOutput("mid_rst_count", countA, 64'd0);
      applyStimulus(1'b0, 1'b1, 5'd4, 64'h400, 64'h80, 1'b0);
      checkOutput("mid_restart_seq", busA.out_seq, 64'd0);
      checkOutput("mid_restart_data", busA.out_data, 64'h400);

      // Freeze: reg_write toggling has no effect, draining still works
      en = 1'b0;
      for (int n = 0; n < 4; n++) begin
         applyStimulus(1'b0, n[0], 5'd3, 64'h500, 64'h84, 1'b0);
      end
      checkOutput("frz_count", countA, 64'd1);
      applyStimulus(1'b0, 1'b1, 5'd3, 64'h501, 64'h88, 1'b1);
      checkOutput("frz_pop_empty", emptyA, 64'd1);
      en = 1'b1;
      applyStimulus(1'b0, 1'b1, 5'd6, 64'h600, 64'h8C, 1'b0);
      checkOutput("unfrz_seq", busA.out_seq, 64'd1);
      checkOutput("unfrz_rd", busA.out_rd, 64'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
